// File: rtl/sam6883_if.sv
// CPU/VDG-side signal bundle for the sam6883 address multiplexer.
// master drives CPU and VDG inputs; slave is the SAM itself.
interface sam6883_if #(
    parameter int RAM_AW = 16
);
    logic [15:0]       cpu_addr;
    logic              cpu_rw;
    logic              da0;
    logic              hs_n;
    logic              fs_n;
    logic              E;
    logic              Q;
    logic              vclk;
    logic [2:0]        S;
    logic [RAM_AW-1:0] z_cpu;
    logic [RAM_AW-1:0] vaddr;
    logic [2:0]        v_mode;

    modport master (
        output cpu_addr, cpu_rw, da0, hs_n, fs_n,
        input  E, Q, vclk, S, z_cpu, vaddr, v_mode
    );

    modport slave (
        input  cpu_addr, cpu_rw, da0, hs_n, fs_n,
        output E, Q, vclk, S, z_cpu, vaddr, v_mode
    );
endinterface

// File: rtl/sam6883.sv
// MC6883-style SAM: E/Q clock pair, 74138 select code, control register,
// CPU address mapping and VDG video address counter.
module sam6883 #(
    parameter int RAM_AW  = 16,
    parameter int CLK_DIV = 14
) (
    input  logic      clk,
    input  logic      reset,
    sam6883_if.slave  bus
);
    localparam int QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QSLOW = QW'(CLK_DIV - 1);
    localparam logic [QW-1:0] QFAST = QW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2, PH3 = 2'd3} phase_e;

    phase_e            phase_q, phase_d;
    logic [QW-1:0]     qcnt_q, qcnt_d;
    logic              fast_q, fast_d, fast_eval;
    logic              cycle_start, quarter_end, commit;
    logic [15:0]       ctrl_q, ctrl_d;
    logic [2:0]        sync1_q, sync2_q, sync3_q, fall;
    logic [RAM_AW-1:0] b_q, b_d, row_q, row_d, mask, zraw;
    logic [3:0]        lc_q, lc_d, ydiv;
    logic [1:0]        xc_q, xc_d, xdiv;
    logic [2:0]        s_code;

    logic [2:0] v;
    logic [6:0] f;
    logic       p, ty;
    logic [1:0] r, m;

    always_comb begin
        v  = ctrl_q[2:0];
        f  = ctrl_q[9:3];
        p  = ctrl_q[10];
        r  = ctrl_q[12:11];
        m  = ctrl_q[14:13];
        ty = ctrl_q[15];
    end

    always_comb begin
        s_code = 3'd0;
        if (bus.cpu_addr[15:8] == 8'hFF) begin
            case (bus.cpu_addr[7:5])
                3'd0:    s_code = 3'd4;
                3'd1:    s_code = 3'd5;
                3'd2:    s_code = 3'd6;
                3'd7:    s_code = 3'd2;
                default: s_code = 3'd7;
            endcase
        end else if (!ty && bus.cpu_addr[15]) begin
            case (bus.cpu_addr[14:13])
                2'b00:   s_code = 3'd1;
                2'b01:   s_code = 3'd2;
                default: s_code = 3'd3;
            endcase
        end
    end

    always_comb begin
        case (m)
            2'b00:   mask = RAM_AW'(16'h0FFF);
            2'b01:   mask = RAM_AW'(16'h3FFF);
            default: mask = '1;
        endcase
        if (!ty && m[1] && !bus.cpu_addr[15])
            zraw = RAM_AW'({p, bus.cpu_addr[14:0]});
        else
            zraw = bus.cpu_addr[RAM_AW-1:0];
    end

    // Rate is re-evaluated only at the first clk of phase 0 and held for the E cycle.
    always_comb begin
        case (r)
            2'b00:   fast_eval = 1'b0;
            2'b01:   fast_eval = (s_code != 3'd0) && (s_code <= 3'd3);
            default: fast_eval = 1'b1;
        endcase
        cycle_start = (phase_q == PH0) && (qcnt_q == '0);
        fast_d      = cycle_start ? fast_eval : fast_q;
        quarter_end = (qcnt_q == (fast_d ? QFAST : QSLOW));
        commit      = quarter_end && (phase_q == PH3);
        phase_d     = phase_q;
        qcnt_d      = qcnt_q + 1'b1;
        if (quarter_end) begin
            qcnt_d = '0;
            case (phase_q)
                PH0:     phase_d = PH1;
                PH1:     phase_d = PH2;
                PH2:     phase_d = PH3;
                default: phase_d = PH0;
            endcase
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (commit && !bus.cpu_rw && bus.cpu_addr[15:5] == 11'h7FE)
            ctrl_d[bus.cpu_addr[4:1]] = bus.cpu_addr[0];
    end

    always_comb begin
        case (v)
            3'b000:  begin xdiv = 2'd1; ydiv = 4'd12; end
            3'b001:  begin xdiv = 2'd3; ydiv = 4'd1;  end
            3'b010:  begin xdiv = 2'd1; ydiv = 4'd3;  end
            3'b011:  begin xdiv = 2'd2; ydiv = 4'd1;  end
            3'b100:  begin xdiv = 2'd1; ydiv = 4'd2;  end
            default: begin xdiv = 2'd1; ydiv = 4'd1;  end
        endcase
    end

    // Only the highest-priority edge acts: fs_n, then hs_n, then da0.
    always_comb begin
        fall  = sync3_q & ~sync2_q;
        b_d   = b_q;
        row_d = row_q;
        lc_d  = lc_q;
        xc_d  = xc_q;
        if (fall[2]) begin
            b_d   = RAM_AW'({f, 9'b0});
            row_d = RAM_AW'({f, 9'b0});
            lc_d  = '0;
            xc_d  = '0;
        end else if (fall[1]) begin
            xc_d = '0;
            if (lc_q == ydiv - 4'd1) begin
                lc_d  = '0;
                row_d = b_q;
            end else begin
                lc_d = lc_q + 4'd1;
                b_d  = row_q;
            end
        end else if (fall[0]) begin
            if (xc_q == xdiv - 2'd1) begin
                xc_d = '0;
                b_d  = b_q + 1'b1;
            end else begin
                xc_d = xc_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH0;
            qcnt_q  <= '0;
            fast_q  <= 1'b0;
            ctrl_q  <= '0;
            sync1_q <= 3'b110;
            sync2_q <= 3'b110;
            sync3_q <= 3'b110;
            b_q     <= '0;
            row_q   <= '0;
            lc_q    <= '0;
            xc_q    <= '0;
        end else begin
            phase_q <= phase_d;
            qcnt_q  <= qcnt_d;
            fast_q  <= fast_d;
            ctrl_q  <= ctrl_d;
            sync1_q <= {bus.fs_n, bus.hs_n, bus.da0};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            b_q     <= b_d;
            row_q   <= row_d;
            lc_q    <= lc_d;
            xc_q    <= xc_d;
        end
    end

    always_comb begin
        bus.E      = (phase_q == PH2) || (phase_q == PH3);
        bus.Q      = (phase_q == PH1) || (phase_q == PH2);
        bus.vclk   = cycle_start && !reset;
        bus.S      = s_code;
        bus.z_cpu  = zraw & mask;
        bus.vaddr  = b_q & mask;
        bus.v_mode = v;
    end
endmodule

// File: doc/sam6883.md
# sam6883

Parametrised synchronous address multiplexer for the CoCo2 core. It replaces the simplified SAM with a full MC6883-style block.
- Generates the E/Q CPU clock pair and the 3-bit chip-select code for the x74138 decode.
- Holds the SAM control register ($FFC0-$FFDF set/clear pairs) for video mode, display offset, page, rate, memory size and map type.
- Generates the VDG video address with per-mode horizontal and vertical dividers, which the old block did not do.
- Sits between mc6809e, the RAM/ROM decode and mc6847.

## Interface
Parameters:
- RAM_AW, 16: RAM address width, 15 or 16.
- CLK_DIV, 14: clk cycles per E quarter-phase at slow rate. Must be even and ≥4; fast rate uses CLK_DIV/2.

Ports:
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address.
- cpu_rw  in  1  CPU read/write: 1 = read, 0 = write.
- da0  in  1  VDG DA0 (byte fetch strobe).
- hs_n  in  1  VDG horizontal sync, active low.
- fs_n  in  1  VDG field sync, active low.
- E  out  1  CPU E clock.
- Q  out  1  CPU Q clock.
- vclk  out  1  one-clk pulse at the start of every E cycle; VDG clock enable.
- S  out  3  select code for the 74138 decode.
- z_cpu  out  RAM_AW  RAM address for the CPU port.
- vaddr  out  RAM_AW  RAM address for the video port.
- v_mode  out  3  current V[2:0], exported for debug.

## Operation
E/Q generation:
- A quarter counter and a 2-bit phase counter (0..3) run continuously.
- Q is high in phases 1 and 2; E is high in phases 2 and 3.
- The quarter length is taken from the rate in effect at phase 0 and held for the whole E cycle.

Rate R[1:0]:
- 00: slow.
- 01: fast when S ∈ {1,2,3} at phase 0, otherwise slow.
- 1x: always fast.

Control register:
- A write to $FFC0+2n clears bit n; a write to $FFC1+2n sets bit n.
- Bit order: V0-V2 (n=0..2), F0-F6 (n=3..9), P (n=10), R0-R1 (n=11..12), M0-M1 (n=13..14), TY (n=15).
- A write is recognised only when cpu_rw=0 and the address is in range. It commits on the clk where phase goes 3→0 (E falling).
- Reads of this range return nothing from this block; S=7.

S decode (combinational from cpu_addr):
- TY=0:
  - $0000-$7FFF → 0
  - $8000-$9FFF → 1
  - $A000-$BFFF → 2
  - $C000-$FEFF → 3
  - $FF00-$FF1F → 4
  - $FF20-$FF3F → 5
  - $FF40-$FF5F → 6
  - $FF60-$FFDF → 7
  - $FFE0-$FFFF → 2 (vectors)
- TY=1: $0000-$FEFF → 0; the $FFxx ranges decode as for TY=0.

z_cpu:
- TY=0 and M=1x: z_cpu = {P, A[14:0]} for A < $8000.
- Otherwise: z_cpu = A[RAM_AW-1:0].
- Then masked by memory size:
  - M=00: 4K, keep bits [11:0].
  - M=01: 16K, keep bits [13:0].
  - M=1x: no mask.

Video counter B (RAM_AW bits), with row_start register, line counter lc and x-divider xc:
- fs_n falling: B and row_start ← {F[6:0], 9'b0} truncated to RAM_AW; lc, xc ← 0.
- da0 falling: xc++. When xc == XDIV-1: xc←0 and B++.
- hs_n falling: xc←0 and lc++.
  - If lc == YDIV-1: lc←0, row_start←B.
  - Else: B←row_start (row repeat).
- V → (XDIV, YDIV): 000 → (1,12), 001 → (3,1), 010 → (1,3), 011 → (2,1), 100 → (1,2), 101/110/111 → (1,1).
- vaddr = B, masked by M as for z_cpu.
- B wraps modulo 2^RAM_AW.

## Timing
- Reset values:
  - E=0, Q=0, vclk=0.
  - Phase 0, quarter counter 0.
  - All control bits 0.
  - B, row_start, lc, xc = 0, so vaddr=0.
  - v_mode=0.
  - S and z_cpu follow the decode of cpu_addr.
- Reset asserted mid-cycle forces these values on the next clk.
- Slow rate, from reset release (clk 0):
  - Q rises at clk CLK_DIV.
  - E rises at 2·CLK_DIV.
  - Q falls at 3·CLK_DIV.
  - E falls at 4·CLK_DIV.
  - vclk pulses at clk 0, 4·CLK_DIV, ...
- da0, hs_n and fs_n pass through a 2-flop synchroniser plus an edge register. The counter effect appears 3 clk after the input edge.
- Edges detected on the same clk, priority: fs_n > hs_n > da0. The lower-priority edge is dropped.
- A control-register commit and a video edge on the same clk: the edge action uses the old V/F values.

## Test plan
- Reset, then run 56 clk at CLK_DIV=14 → Q rises @14, E rises @28, Q falls @42, E falls @56; vclk pulses at 0 and 56; all outputs at reset values.
- Decode with TY=0: cpu_addr $FFFE → S=2; $FF22 → S=5; $C000 → S=3. Write $FFDF, then $9000 → S=0.
- Write $FFC7 (F0 set), then pulse fs_n low → vaddr=$0200 three clk after the edge.
- V=000, F=2, 32 da0 pulses per line, 12 hs_n pulses:
  - vaddr returns to $0400 after each of the first 11 lines.
  - vaddr is $0420 after the 12th line.
- Set P ($FFD5) and M=10 ($FFDD), read $1234 → z_cpu=$9234. With M=00 → z_cpu=$0234.
- Write $FFD9 (R1 set) → the next E cycle after commit has a period of 28 clk. Write $FFD8 → the period returns to 56.
